// File: rtl/nibble_serial_add_ctrl_pkg.sv
// nibble_serial_add_ctrl_pkg: shared FSM encoding and nibble width for the serial adder
package nibble_serial_add_ctrl_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/nibble_serial_add_ctrl_nibble_add4.sv
// nibble_add4: combinational 4-bit ripple-carry adder cell shared across nibble steps
module nibble_add4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);
  logic [NIB_W:0] c;
  // carry ripples bit by bit through the nibble
  always_comb begin
    c[0] = ci;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[NIB_W];
  end
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add over WIDTH/4 cycles on one 4-bit adder (optional subtract: NIBBLE_SERIAL_ADD_SUB_EN)
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
  state_t                      state, state_nx;
  logic [NIB-1:0][NIB_W-1:0]   a_r, b_r, sum_r;
  logic [IW-1:0]               idx;
  logic                        carry, last, ad_co;
  logic [NIB_W-1:0]            ad_s;
  logic [WIDTH-1:0]            b_in;
  logic                        c_in;

`ifdef NIBBLE_SERIAL_ADD_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign last = idx == IW'(NIB - 1);
  assign sum  = sum_r;

  nibble_add4 u_add (
    .a  (a_r[idx]),
    .b  (b_r[idx]),
    .ci (carry),
    .s  (ad_s),
    .co (ad_co)
  );

  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  // next state: abort beats the final-nibble transition
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE)
             : state == RUN  ? (abort ? IDLE : last ? DONE : RUN)
             : IDLE;
  end

  // handshake outputs decoded from state
  always_comb begin
    ready = state == IDLE;
    busy  = state == RUN;
    done  = state == DONE;
  end

  // operand latch on accept, one nibble of sum per RUN edge
  always_ff @(posedge clk)
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      idx   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r   <= a;
      b_r   <= b_in;
      carry <= c_in;
      idx   <= '0;
    end else if (state == RUN && !abort) begin
      sum_r[idx] <= ad_s;
      carry      <= ad_co;
      idx        <= idx + 1'b1;
      if (last) cout <= ad_co;
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: randomized scoreboard bench for the serial nibble adder
module tb_nibble_serial_add_ctrl;
  localparam int W = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           acc;
  } exp_t;

  logic clk = 0, rst_n = 0, start = 0, abort = 0, cin = 0;
  logic [W-1:0] a = '0, b = '0;
  logic ready, busy, done, cout;
  logic [W-1:0] sum;
  logic rst4 = 0, start4 = 0, abort4 = 0, cin4 = 0;
  logic [3:0] a4 = '0, b4 = '0;
  logic ready4, busy4, done4, cout4;
  logic [3:0] sum4;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
  logic sub = 0, sub4 = 0;
`endif

  int total = 0, bad = 0, cyc = 0, brun = 0;
  exp_t q[$], q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .abort(abort), .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    .sub(sub4),
`endif
    .abort(abort4), .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb, input int acc);
    longint r;
    exp_t e;
    r = sb ? longint'(x) - longint'(y) + (longint'(1) << W) : longint'(x) + longint'(y) + longint'(ci);
    e.s = W'(r);
    e.c = r[W];
    e.acc = acc;
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", ready, 1);
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb, input bit push);
    wait_ready();
    a = x;
    b = y;
    cin = ci;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    sub = sb;
`endif
    start = 1;
    @(posedge clk);
    #1;
    if (push) q.push_back(model(x, y, ci, sb, cyc));
    @(negedge clk);
    start = 0;
  endtask

  task automatic issue4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    int n = 0;
    exp_t e;
    while (!ready4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready4_before_start", ready4, 1);
    a4 = x;
    b4 = y;
    cin4 = ci;
    start4 = 1;
    @(posedge clk);
    #1;
    e.s = W'(int'(x) + int'(y) + int'(ci));
    e.c = e.s[4];
    e.s = e.s & W'(15);
    e.acc = cyc;
    q4.push_back(e);
    @(negedge clk);
    start4 = 0;
  endtask

  // monitor for the WIDTH=16 instance
  always @(negedge clk) begin
    exp_t e;
    if (ready) brun = 0;
    else if (busy) brun++;
    if (done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want done=0");
      end else begin
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("cout", cout, e.c);
        chk("latency", cyc - e.acc, NIB);
        chk("busy_cycles", brun, NIB);
      end
    end
  end

  // monitor for the WIDTH=4 instance
  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done4: got done=1 want done=0");
      end else begin
        e = q4.pop_front();
        chk("sum4", sum4, e.s[3:0]);
        chk("cout4", cout4, e.c);
        chk("latency4", cyc - e.acc, 1);
      end
    end
  end

  initial begin
    int c0, n;
    logic sb;
    repeat (2) @(negedge clk);
    rst_n = 1;
    rst4 = 1;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    issue(16'h1234, 16'h4321, 0, 0, 1);
    issue(16'hFFFF, 16'h0001, 0, 0, 1);
    issue(16'h0FFF, 16'h0000, 1, 0, 1);
    wait_ready();
    a = 16'h1111;
    b = 16'h2222;
    cin = 1;
    start = 1;
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) q.push_back(model(16'h1111, 16'h2222, 1, 0, c0 + 6 * i));
    repeat (12) @(posedge clk);
    @(negedge clk);
    start = 0;
    issue(16'hABCD, 16'h1357, 1, 0, 1);
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    issue(16'hFFFF, 16'h0001, 0, 0, 1);
    issue(16'h1234, 16'h4321, 0, 0, 0);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_cout", cout, 1);
    issue(16'h1234, 16'h4321, 0, 0, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrun_rst_sum", sum, 0);
    chk("midrun_rst_cout", cout, 0);
    chk("midrun_rst_ready", ready, 1);
    issue(16'h0001, 16'h0001, 0, 0, 1);
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    issue(16'h0005, 16'h0007, 0, 1, 1);
    issue(16'h0007, 16'h0005, 0, 1, 1);
`endif
    for (int i = 0; i < 30; i++) begin
      sb = 0;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
      sb = 1'($urandom);
`endif
      issue(16'($urandom), 16'($urandom), 1'($urandom), sb, 1);
    end
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    sub = 0;
`endif
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) issue4(4'(x), 4'(y), 1'(c));
    n = 0;
    while ((q.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", q.size() + q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
